// File: rtl/rf_sched_pkg.sv
// Shared widths and types for the register-file writeback scheduler.
package rf_sched_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [NUM_REGS-1:0]  busy_vec_t;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Issue, writeback and register-file write signals of the writeback scheduler.
interface rf_wb_scheduler_if;
    import rf_sched_pkg::*;

    logic             issue_valid;
    reg_idx_t         issue_rs1_idx;
    reg_idx_t         issue_rs2_idx;
    logic             issue_uses_rs1;
    logic             issue_uses_rs2;
    reg_idx_t         issue_rd_idx;
    logic             issue_long;
    logic             issue_stall;

    logic             pipe_wb_valid;
    reg_idx_t         pipe_wb_rd;
    logic [XLEN-1:0]  pipe_wb_data;

    logic             lu_wb_valid;
    reg_idx_t         lu_wb_rd;
    logic [XLEN-1:0]  lu_wb_data;
    logic             lu_wb_ready;

    logic             rf_wen;
    reg_idx_t         rf_rd_idx;
    logic [XLEN-1:0]  rf_wdata;

    modport master (
        output issue_valid, issue_rs1_idx, issue_rs2_idx, issue_uses_rs1, issue_uses_rs2,
               issue_rd_idx, issue_long,
               pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
               lu_wb_valid, lu_wb_rd, lu_wb_data,
        input  issue_stall, lu_wb_ready, rf_wen, rf_rd_idx, rf_wdata
    );

    modport slave (
        input  issue_valid, issue_rs1_idx, issue_rs2_idx, issue_uses_rs1, issue_uses_rs2,
               issue_rd_idx, issue_long,
               pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
               lu_wb_valid, lu_wb_rd, lu_wb_data,
        output issue_stall, lu_wb_ready, rf_wen, rf_rd_idx, rf_wdata
    );

endinterface

// File: rtl/rf_wb_arb.sv
// RF write-port mux (pipe has fixed priority) plus LU starvation counter and issue throttle.
// Optional RF_SCHED_PERF_EN adds the throttle_rise pulse used by the perf counters.
module rf_wb_arb
    import rf_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic            pipe_wb_valid,
    input  reg_idx_t        pipe_wb_rd,
    input  logic [XLEN-1:0] pipe_wb_data,
    input  logic            lu_wb_valid,
    input  reg_idx_t        lu_wb_rd,
    input  logic [XLEN-1:0] lu_wb_data,
    output logic            lu_wb_ready,
    output logic            rf_wen,
    output reg_idx_t        rf_rd_idx,
    output logic [XLEN-1:0] rf_wdata,
    output logic            throttle
`ifdef RF_SCHED_PERF_EN
    ,
    output logic            throttle_rise
`endif
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                pipe_occ;
    logic                refused;
    logic                commit;
    logic                throttle_set;
    logic [STARVE_W-1:0] starve_q;

    // Port mux: a pipe write to x0 is not an occupant, so the LU may use that cycle.
    always_comb begin
        rf_wen    = 1'b0;
        rf_rd_idx = '0;
        rf_wdata  = '0;
        pipe_occ  = pipe_wb_valid & (pipe_wb_rd != '0);
        if (pipe_occ) begin
            rf_wen    = 1'b1;
            rf_rd_idx = pipe_wb_rd;
            rf_wdata  = pipe_wb_data;
        end else if (lu_wb_valid) begin
            rf_wen    = (lu_wb_rd != '0);
            rf_rd_idx = lu_wb_rd;
            rf_wdata  = lu_wb_data;
        end
    end

    assign lu_wb_ready  = ~pipe_occ;
    assign refused      = lu_wb_valid & pipe_occ;
    assign commit       = lu_wb_valid & ~pipe_occ;
    // Throttle lands on the same edge the starve count reaches the limit.
    assign throttle_set = refused & (starve_q == STARVE_W'(STARVE_LIMIT - 1));

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            starve_q <= '0;
            throttle <= 1'b0;
        end else begin
            if (!refused)
                starve_q <= '0;
            else if (starve_q != STARVE_W'(STARVE_LIMIT))
                starve_q <= starve_q + STARVE_W'(1);

            if (commit)
                throttle <= 1'b0;
            else if (throttle_set)
                throttle <= 1'b1;
        end
    end

`ifdef RF_SCHED_PERF_EN
    assign throttle_rise = throttle_set & ~throttle;
`endif

endmodule

// File: rtl/rf_wb_scheduler.sv
// RF write-port scheduler and long-latency scoreboard for the single-write-port register file.
// Optional feature: define RF_SCHED_PERF_EN for stall-cycle and starve-event counters.
module rf_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    rf_wb_scheduler_if.slave  bus,
    output busy_vec_t         busy_vec
`ifdef RF_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_starve_events
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    busy_vec_t   busy_q;
    busy_vec_t   busy_set;
    busy_vec_t   busy_clr;
    logic [CNT_W-1:0] outst_q;
    logic        throttle;
    logic        lu_commit;
    logic        outst_full;
    logic        haz;
    logic        accept;
`ifdef RF_SCHED_PERF_EN
    logic        throttle_rise;
`endif

    rf_wb_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .pipe_wb_valid (bus.pipe_wb_valid),
        .pipe_wb_rd    (bus.pipe_wb_rd),
        .pipe_wb_data  (bus.pipe_wb_data),
        .lu_wb_valid   (bus.lu_wb_valid),
        .lu_wb_rd      (bus.lu_wb_rd),
        .lu_wb_data    (bus.lu_wb_data),
        .lu_wb_ready   (bus.lu_wb_ready),
        .rf_wen        (bus.rf_wen),
        .rf_rd_idx     (bus.rf_rd_idx),
        .rf_wdata      (bus.rf_wdata),
        .throttle      (throttle)
`ifdef RF_SCHED_PERF_EN
        ,
        .throttle_rise (throttle_rise)
`endif
    );

    assign lu_commit  = bus.lu_wb_valid & bus.lu_wb_ready;
    assign outst_full = (outst_q == CNT_W'(MAX_OUTSTANDING));

    // Hazards use the registered scoreboard, so a same-cycle commit does not release a reader.
    always_comb begin
        haz = (bus.issue_uses_rs1 & busy_q[bus.issue_rs1_idx])
            | (bus.issue_uses_rs2 & busy_q[bus.issue_rs2_idx])
            | busy_q[bus.issue_rd_idx]
            | (bus.issue_long & outst_full)
            | throttle;
        accept   = bus.issue_valid & ~haz & bus.issue_long;
        busy_set = '0;
        busy_clr = '0;
        if (accept && (bus.issue_rd_idx != '0))
            busy_set = busy_vec_t'(1) << bus.issue_rd_idx;
        if (lu_commit && (bus.lu_wb_rd != '0))
            busy_clr = busy_vec_t'(1) << bus.lu_wb_rd;
    end

    assign bus.issue_stall = bus.issue_valid & haz;
    assign busy_vec        = busy_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            busy_q  <= '0;
            outst_q <= '0;
        end else begin
            busy_q <= (busy_q & ~busy_clr) | busy_set;
            case ({accept, lu_commit})
                2'b10:   outst_q <= outst_q + CNT_W'(1);
                2'b01:   outst_q <= outst_q - CNT_W'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    // Protocol checks on the outstanding counter.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            assert (!(lu_commit && (outst_q == '0)))
                else $error("rf_wb_scheduler: LU commit with no outstanding op");
            assert (!(accept && !lu_commit && outst_full))
                else $error("rf_wb_scheduler: outstanding count overflow");
        end
    end

`ifdef RF_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] starve_ev_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            stall_cnt_q <= '0;
            starve_ev_q <= '0;
        end else begin
            if (bus.issue_stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (throttle_rise && (starve_ev_q != '1))
                starve_ev_q <= starve_ev_q + 32'd1;
        end
    end

    assign perf_stall_cycles  = stall_cnt_q;
    assign perf_starve_events = starve_ev_q;
`endif

endmodule
